// File: rtl/data_burst_pkg.sv
// Shared burst parameters and FSM encoding.
// Used by the burst source and the capture buffer.
package data_burst_pkg;

  localparam int BURST_WIDTH  = 16;
  localparam int BURST_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/data_burst_source_fifo.sv
// Synchronous FIFO with a combinational head word.
// Pointers wrap modulo DEPTH (power of two).
module burst_fifo
  import data_burst_pkg::*;
#(
  parameter int WIDTH = BURST_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_burst_source.sv
// Buffers a word stream and replays it as fixed
// CYCLES-word bursts behind a one-cycle start strobe.
module data_burst_source
  import data_burst_pkg::*;
#(
  parameter int WIDTH  = BURST_WIDTH,
  parameter int CYCLES = BURST_CYCLES,
  parameter int DEPTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   data_start,
  output logic [WIDTH-1:0]       data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Occupancy seen at the last beat, where no pop occurs.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, push};

  burst_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Burst sequencing; pop on every edge that enters a word cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count >= CW'(CYCLES)) state_d = START;
      end
      START: begin
        state_d = SEND;
        beat_d  = '0;
        pop     = !empty;
      end
      SEND: begin
        if (beat_q == BW'(CYCLES - 1)) begin
          if (occ >= (CW+1)'(CYCLES)) state_d = START;
          else                        state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
          pop    = !empty;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    data_d  = pop ? head : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign data_start = start_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign fifo_count = count;

endmodule
